fifo_stream_reader: RTL and testbench
=====================================

# fifo_stream_reader

Read-side stage placed directly downstream of the accelerator's FIFO pointer controller and its buffer RAM. It issues pops while the FIFO is non-empty and absorbs the RAM's fixed read latency. Returned words go into a small local skid buffer, which presents them to the next stage (MAC array / activation loader) on a valid/ready stream. Full throughput is one word per cycle, and no word is lost or duplicated under back-pressure.

## Interface
Parameters:
- WIDTH, 16, data word width in bits.
- READ_LATENCY, 1, cycles from pop to data on mem_rdata; legal range 1..4.
- BUF_DEPTH (localparam) = READ_LATENCY+1, skid buffer entries.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- fifo_empty  input  1  FIFO controller empty flag.
- fifo_read_enable  output  1  pop request to FIFO controller; RAM is addressed by the controller's read pointer.
- mem_rdata  input  WIDTH  RAM read data, valid exactly READ_LATENCY cycles after a pop.
- out_valid  output  1  out_data holds a word.
- out_ready  input  1  consumer accepts when out_valid & out_ready.
- out_data  output  WIDTH  head-of-buffer word.
- beat_count  output  32  only with FIFO_READER_STATS_EN.
- stall_count  output  32  only with FIFO_READER_STATS_EN.

## Operation
- State:
  - inflight: shift register of READ_LATENCY valid bits, one per outstanding pop.
  - occupancy: 0..BUF_DEPTH.
  - Buffer: BUF_DEPTH x WIDTH circular storage, with head/tail pointers.
- fire = out_valid & out_ready.
- credit = BUF_DEPTH - popcount(inflight) - occupancy + fire.
- fifo_read_enable = ~reset & ~fifo_empty & (credit > 0). Combinational from registered state, fifo_empty and out_ready.
- Each cycle, inflight shifts in fifo_read_enable. The bit leaving the pipeline (arrive) writes mem_rdata at tail.
- Occupancy update: occupancy' = occupancy + arrive - fire.
  - Simultaneous arrive and fire is legal, including at occupancy 0 → 1 → 0 and at full.
- out_valid = (occupancy != 0). out_data = buffer[head]. No bypass from mem_rdata to out_data.
- Pointers wrap modulo BUF_DEPTH. Overflow is impossible by the credit rule; an assertion must flag arrive with occupancy == BUF_DEPTH and fire=0.
- out_data is stable while out_valid & ~out_ready.
- Words leave in pop order.
- Reset mid-operation:
  - Clears inflight, occupancy and pointers immediately.
  - Data returning from pre-reset pops is ignored.
  - Words already popped from the FIFO are lost; this is accepted.

## Timing
- Reset values: fifo_read_enable 0, out_valid 0, out_data 0, occupancy 0, inflight 0, counters 0.
- Pop at cycle t → mem_rdata sampled at end of cycle t+READ_LATENCY → out_valid at t+READ_LATENCY+1.
- First-word latency from fifo_empty deasserting: READ_LATENCY+1 cycles.
- Steady state with out_ready held high: one pop and one output beat every cycle.
- With out_ready low, at most BUF_DEPTH pops are outstanding/buffered; popping then stops until a fire.
- Restart after out_ready rises: a pop is issued in the same cycle as the fire.
  - No bubble in output, since buffered words cover the latency.

## Configuration
- FIFO_READER_STATS_EN defined:
  - beat_count increments on every fire.
  - stall_count increments every cycle with out_valid & ~out_ready.
  - Both are 32-bit, wrap at 2^32-1 → 0, and are cleared by reset.
- FIFO_READER_STATS_EN undefined:
  - Both ports and their registers are absent.
  - All other behaviour is identical.

## Test plan
- Reset then fifo_empty=1 for 20 cycles → fifo_read_enable, out_valid stay 0.
- READ_LATENCY=1; 8 words 0x0001..0x0008 preloaded; out_ready=1 → pops on 8 consecutive cycles; out_data 0x0001..0x0008 on 8 consecutive cycles starting 2 cycles after first pop.
- READ_LATENCY=3; out_ready=0 with 10 words queued:
  - Exactly 4 pops, then fifo_read_enable=0.
  - After out_ready=1: 10 words in order, no gaps.
  - stall_count equals the number of cycles with out_valid=1 and out_ready=0.
- Random out_ready (50%), 200 words 0..199 → output sequence exactly 0..199; assertion never fires; beat_count=200.
- Reset asserted 1 cycle after a pop with READ_LATENCY=2 → out_valid stays 0 after reset release; returned stale mem_rdata never appears.
- fifo_empty toggling every cycle with out_ready=1 → pops only in non-empty cycles; output count equals pop count.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read side of the accelerator FIFO: pops while data is available, absorbs the RAM read latency
// and hands words on through a small skid buffer. Define FIFO_READER_STATS_EN for beat/stall counters.
module fifo_stream_reader #(
    parameter int WIDTH        = 16,
    parameter int READ_LATENCY = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fifo_empty,
    output logic             fifo_read_enable,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef FIFO_READER_STATS_EN
    ,
    output logic [31:0]      beat_count,
    output logic [31:0]      stall_count
`endif
);

    localparam int BUF_DEPTH = READ_LATENCY + 1;
    localparam int PTR_W     = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W     = 4;

    logic [READ_LATENCY-1:0] inflight_r;
    logic [CNT_W-1:0]        occupancy_r;
    logic [PTR_W-1:0]        head_r;
    logic [PTR_W-1:0]        tail_r;
    logic [WIDTH-1:0]        buffer_r [BUF_DEPTH];

    logic                    fire_s;
    logic                    arrive_s;
    logic [CNT_W-1:0]        credit_s;

    function automatic logic [CNT_W-1:0] popcount(input logic [READ_LATENCY-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = {CNT_W{1'b0}};
        for (int i = 0; i < READ_LATENCY; i++) begin
            cnt = cnt + CNT_W'(v[i]);
        end
        return cnt;
    endfunction

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
    endfunction

    assign out_valid = (occupancy_r != {CNT_W{1'b0}});
    assign out_data  = buffer_r[head_r];

    // Credit counts free slots, with slots still promised to outstanding pops counted as taken.
    // Sum before subtracting so the unsigned result never wraps.
    always_comb begin
        fire_s           = out_valid & out_ready;
        arrive_s         = inflight_r[READ_LATENCY-1];
        credit_s         = CNT_W'(BUF_DEPTH) + CNT_W'(fire_s) - popcount(inflight_r) - occupancy_r;
        fifo_read_enable = ~reset & ~fifo_empty & (credit_s != {CNT_W{1'b0}});
    end

    // Latency pipeline, skid buffer storage, pointers and occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_r  <= {READ_LATENCY{1'b0}};
            occupancy_r <= {CNT_W{1'b0}};
            head_r      <= {PTR_W{1'b0}};
            tail_r      <= {PTR_W{1'b0}};
            for (int i = 0; i < BUF_DEPTH; i++) begin
                buffer_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            inflight_r <= (inflight_r << 1) | READ_LATENCY'(fifo_read_enable);
            if (arrive_s) begin
                buffer_r[tail_r] <= mem_rdata;
                tail_r           <= next_ptr(tail_r);
            end
            if (fire_s) begin
                head_r <= next_ptr(head_r);
            end
            occupancy_r <= occupancy_r + CNT_W'(arrive_s) - CNT_W'(fire_s);
        end
    end

`ifdef FIFO_READER_STATS_EN
    // Output beat and back-pressure counters, wrapping naturally at 32 bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            beat_count  <= 32'd0;
            stall_count <= 32'd0;
        end else begin
            if (fire_s) begin
                beat_count <= beat_count + 32'd1;
            end
            if (out_valid & ~out_ready) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end
`endif

    // A word arriving into a full buffer with nothing leaving would be lost.
    overflow_chk: assert property (@(posedge clk) disable iff (reset)
        !(arrive_s && !fire_s && (occupancy_r == CNT_W'(BUF_DEPTH))))
        else $error("fifo_stream_reader: arrival into full skid buffer");

    hold_chk: assert property (@(posedge clk) disable iff (reset)
        (out_valid && !out_ready) |=> $stable(out_data))
        else $error("fifo_stream_reader: out_data changed while stalled");

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench: three readers (read latency 1, 2, 3) each fed by a FIFO/RAM model.
module tb_fifo_stream_reader;
    localparam int W = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset;
    logic [2:0]   fifo_empty, fre, ov, ordy, gate;
    logic [W-1:0] rdata [3];
    logic [W-1:0] odata [3];
`ifdef FIFO_READER_STATS_EN
    logic [31:0]  beat_count [3];
    logic [31:0]  stall_count [3];
`endif

    int total [3] = '{0, 0, 0};
    int base [3] = '{0, 0, 0};
    int pops [3] = '{0, 0, 0};
    int stalls [3] = '{0, 0, 0};
    int bad_pops [3] = '{0, 0, 0};
    int cyc = 0;
    logic [W-1:0] pipe [3][4] = '{default: 16'hDEAD};
    logic [W-1:0] outq [3][$];
    int out_cyc [3][$];
    int pop_cyc [3][$];

    int checks = 0;
    int errors = 0;

    always_comb begin
        for (int k = 0; k < 3; k++) begin
            fifo_empty[k] = gate[k] | (pops[k] >= total[k]);
        end
    end

    assign rdata[0] = pipe[0][0];
    assign rdata[1] = pipe[1][1];
    assign rdata[2] = pipe[2][2];

    fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(1)) u_rl1 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty[0]), .fifo_read_enable(fre[0]),
        .mem_rdata(rdata[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(odata[0])
`ifdef FIFO_READER_STATS_EN
        , .beat_count(beat_count[0]), .stall_count(stall_count[0])
`endif
    );

    fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(2)) u_rl2 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty[1]), .fifo_read_enable(fre[1]),
        .mem_rdata(rdata[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(odata[1])
`ifdef FIFO_READER_STATS_EN
        , .beat_count(beat_count[1]), .stall_count(stall_count[1])
`endif
    );

    fifo_stream_reader #(.WIDTH(W), .READ_LATENCY(3)) u_rl3 (
        .clk(clk), .reset(reset), .fifo_empty(fifo_empty[2]), .fifo_read_enable(fre[2]),
        .mem_rdata(rdata[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(odata[2])
`ifdef FIFO_READER_STATS_EN
        , .beat_count(beat_count[2]), .stall_count(stall_count[2])
`endif
    );

    // FIFO + RAM model: word index n holds base+n; returns 16'hDEAD when no pop was made.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int k = 0; k < 3; k++) begin
            if (fre[k]) begin
                pops[k] <= pops[k] + 1;
                pop_cyc[k].push_back(cyc);
                if (fifo_empty[k]) bad_pops[k] <= bad_pops[k] + 1;
            end
            pipe[k][0] <= fre[k] ? W'(base[k] + pops[k]) : 16'hDEAD;
            for (int j = 1; j < 4; j++) pipe[k][j] <= pipe[k][j-1];
            if (ov[k] && ordy[k]) begin
                outq[k].push_back(odata[k]);
                out_cyc[k].push_back(cyc);
            end
            if (ov[k] && !ordy[k]) stalls[k] <= stalls[k] + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        int t0;
        int t1;
        int bad;
        reset = 1'b1;
        gate  = 3'b111;
        ordy  = 3'b000;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_fre", 32'(fre), 32'd0);
        check("rst_valid", 32'(ov), 32'd0);
        for (int k = 0; k < 3; k++) check("rst_data", 32'(odata[k]), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("rst_beats", beat_count[0], 32'd0);
        check("rst_stalls", stall_count[0], 32'd0);
`endif
        reset = 1'b0;

        // Empty FIFO for 20 cycles: nothing happens
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_fre", 32'(fre), 32'd0);
            check("idle_valid", 32'(ov), 32'd0);
        end

        // Latency 1, eight words, consumer always ready
        base[0] = 1; total[0] = 8; ordy[0] = 1'b1; gate[0] = 1'b0; t0 = cyc;
        repeat (14) @(negedge clk);
        check("rl1_pops", pops[0], 32'd8);
        check("rl1_count", outq[0].size(), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check("rl1_pop_cycle", pop_cyc[0][i], t0 + i);
            check("rl1_data", 32'(outq[0][i]), i + 1);
            check("rl1_out_cycle", out_cyc[0][i], t0 + 2 + i);
        end
        check("rl1_drained", 32'(ov[0]), 32'd0);

        // Latency 3, ten words, consumer stalled
        base[2] = 100; total[2] = 10; ordy[2] = 1'b0; gate[2] = 1'b0; t0 = cyc;
        repeat (12) @(negedge clk);
        check("bp_pops", pops[2], 32'd4);
        check("bp_fre", 32'(fre[2]), 32'd0);
        check("bp_valid", 32'(ov[2]), 32'd1);
        check("bp_head", 32'(odata[2]), 32'd100);
        repeat (2) @(negedge clk);
        check("bp_hold", 32'(odata[2]), 32'd100);
        check("bp_pops_hold", pops[2], 32'd4);
        check("bp_stall_cycles", stalls[2], 32'd10);
`ifdef FIFO_READER_STATS_EN
        check("bp_stall_count", stall_count[2], 32'd10);
`endif
        ordy[2] = 1'b1; t1 = cyc;
        repeat (20) @(negedge clk);
        check("bp_count", outq[2].size(), 32'd10);
        check("bp_total_pops", pops[2], 32'd10);
        check("bp_restart_pop", pop_cyc[2][4], t1);
        for (int i = 0; i < 10; i++) begin
            check("bp_data", 32'(outq[2][i]), 100 + i);
            check("bp_out_cycle", out_cyc[2][i], t1 + i);
        end
`ifdef FIFO_READER_STATS_EN
        check("bp_beats", beat_count[2], 32'd10);
        check("bp_stall_final", stall_count[2], 32'd10);
`endif

        // Random back-pressure, 200 words 0..199 on latency 3
        base[2] = -10; total[2] = 210;
        for (int n = 0; n < 3000 && outq[2].size() < 210; n++) begin
            ordy[2] = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ordy[2] = 1'b1;
        repeat (2) @(negedge clk);
        check("rand_count", outq[2].size(), 32'd210);
        bad = 0;
        for (int i = 10; i < 210; i++) begin
            if (outq[2][i] !== W'(i - 10)) bad++;
        end
        check("rand_order", bad, 32'd0);
        check("rand_pops", pops[2], 32'd210);
        check("rand_valid", 32'(ov[2]), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("rand_beats", beat_count[2], 32'd210);
        check("rand_stalls", stall_count[2], stalls[2]);
`endif

        // Reset one cycle after a pop on latency 2: the returning word must be dropped
        base[1] = 500; total[1] = 1; ordy[1] = 1'b1; gate[1] = 1'b0;
        @(negedge clk);
        check("rst_mid_pop", pops[1], 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_mid_fre", 32'(fre), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_mid_valid", 32'(ov[1]), 32'd0);
        end
        check("rst_mid_count", outq[1].size(), 32'd0);
        check("rst_mid_data", 32'(odata[1]), 32'd0);
`ifdef FIFO_READER_STATS_EN
        check("rst_mid_beats", beat_count[2], 32'd0);
`endif
        total[1] = 2;
        repeat (6) @(negedge clk);
        check("rst_after_count", outq[1].size(), 32'd1);
        check("rst_after_data", 32'(outq[1][0]), 32'd501);

        // fifo_empty toggling every cycle on latency 1, ten more words 9..18
        total[0] = 18; ordy[0] = 1'b1;
        for (int i = 0; i < 20; i++) begin
            gate[0] = i[0];
            @(negedge clk);
        end
        gate[0] = 1'b1;
        repeat (5) @(negedge clk);
        check("tog_pops", pops[0], 32'd18);
        check("tog_pop_when_empty", bad_pops[0], 32'd0);
        check("tog_out_eq_pops", outq[0].size(), pops[0]);
        bad = 0;
        for (int i = 8; i < 18; i++) begin
            if (outq[0][i] !== W'(i + 1)) bad++;
        end
        check("tog_order", bad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
